seq_tx: RTL



---
 rtl/seq_tx_pkg.sv | 24 ++
 rtl/seq_tx_shreg.sv | 47 ++++
 rtl/seq_tx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter and its detector bench.
// SEQ_TX_PARITY_EN (optional define) appends an even-parity bit to every frame.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } seq_tx_state_e;

    localparam logic [11:0] SEQ_PATTERN = 12'b1110_1101_1011;

`ifdef SEQ_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Counter width helper: never returns less than one bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-first shift register; zeros enter at the LSB so it drains to all-zero.
module seq_tx_shreg #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             msb
);

    logic [WIDTH-1:0] sh_reg;
    logic [WIDTH-1:0] sh_next;
    logic [WIDTH-1:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign shifted[gi] = 1'b0;
            end else begin : g_upper
                assign shifted[gi] = sh_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        sh_next = sh_reg;
        if (load) begin
            sh_next = load_data;
        end else if (shift) begin
            sh_next = shifted;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_reg <= '0;
        end else begin
            sh_reg <= sh_next;
        end
    end

    assign msb = sh_reg[WIDTH-1];

endmodule

// File: rtl/seq_tx.sv
// Serial pattern transmitter: valid/ready word in, MSB-first bit stream out on x_o.
// Optional define SEQ_TX_PARITY_EN appends an even-parity bit after the data LSB.
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH      = 12,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             x_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int FRAME_LEN = WIDTH + PARITY_BITS;
    localparam int CW        = clog2_min1(FRAME_LEN + 1);
    localparam int GW        = clog2_min1(GAP_CYCLES + 1);

    localparam logic [CW-1:0] BIT_FIRST = CW'(1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(FRAME_LEN);
    localparam logic [GW-1:0] GAP_FIRST = GW'(1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES);
    localparam logic          HAS_GAP   = (GAP_CYCLES > 0);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_GAP   = ST_GAP;

    logic [1:0]           state_reg;
    logic [1:0]           state_next;
    logic [CW-1:0]        bit_cnt_reg;
    logic [CW-1:0]        bit_cnt_next;
    logic [GW-1:0]        gap_cnt_reg;
    logic [GW-1:0]        gap_cnt_next;
    logic                 last_bit;
    logic                 accept;
    logic                 sh_load;
    logic                 sh_shift;
    logic [FRAME_LEN-1:0] frame_word;

`ifdef SEQ_TX_PARITY_EN
    assign frame_word = {data_i, ^data_i};
`else
    assign frame_word = data_i;
`endif

    // bit_cnt counts the frame bit currently visible on x_o (1..FRAME_LEN).
    assign last_bit = (state_reg == S_SHIFT) && (bit_cnt_reg == BIT_LAST);
    assign ready_o  = (state_reg == S_IDLE) || (!HAS_GAP && last_bit);
    assign accept   = valid_i && ready_o;
    assign busy_o   = (state_reg != S_IDLE);
    assign done_o   = last_bit;

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next   = S_SHIFT;
                    bit_cnt_next = BIT_FIRST;
                    sh_load      = 1'b1;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    if (accept) begin
                        bit_cnt_next = BIT_FIRST;
                        sh_load      = 1'b1;
                    end else begin
                        // One more shift empties the register so x_o returns to 0.
                        sh_shift     = 1'b1;
                        bit_cnt_next = '0;
                        if (HAS_GAP) begin
                            state_next   = S_GAP;
                            gap_cnt_next = GAP_FIRST;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                end else begin
                    sh_shift     = 1'b1;
                    bit_cnt_next = bit_cnt_reg + CW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next   = S_IDLE;
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GW'(1);
                end
            end
            default: begin
                state_next   = S_IDLE;
                bit_cnt_next = '0;
                gap_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    seq_tx_shreg #(
        .WIDTH (FRAME_LEN)
    ) u_shreg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (sh_load),
        .shift     (sh_shift),
        .load_data (frame_word),
        .msb       (x_o)
    );

endmodule
